// File: rtl/ft232r_rsp_arb.sv
// Round-robin arbiter that funnels per-requester 4-phase byte handshakes onto the FT232R response path.
// Define FT232R_ARB_PKT_LOCK_EN to keep a requester's multi-byte packet together using its last flag.
module ft232r_rsp_arb #(
   parameter int N_REQ = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] data,
   input  logic [N_REQ-1:0]   last,
   output logic [N_REQ-1:0]   ack,
   output logic               rsp_req,
   output logic [7:0]         rsp_data,
   input  logic               rsp_ack,
   output logic [N_REQ-1:0]   grant,
   output logic               busy
);
   localparam int IW = $clog2(N_REQ);
   localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_ACK} state_t;

   state_t           state_reg, state_next;
   logic [IW-1:0]    ptr_reg, ptr_next;
   logic [IW-1:0]    g_reg, g_next;
   logic [N_REQ-1:0] grant_reg, grant_next;
   logic [N_REQ-1:0] ack_reg, ack_next;
   logic             rsp_req_reg, rsp_req_next;
   logic [7:0]       rsp_data_reg, rsp_data_next;

   logic [7:0]       byte_arr [N_REQ];
   logic [N_REQ-1:0] elig;
   logic             sel_vld;
   logic [IW-1:0]    sel_idx;
   logic [IW-1:0]    g_inc;

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
         assign byte_arr[gi] = data[8*gi +: 8];
      end
   endgenerate

`ifdef FT232R_ARB_PKT_LOCK_EN
   logic          lock_vld_reg, lock_vld_next;
   logic [IW-1:0] lock_idx_reg, lock_idx_next;
   logic          last_reg, last_next;

   // While a packet is open only its owner may be granted.
   assign elig = lock_vld_reg ? (req & (ONE << lock_idx_reg)) : req;
`else
   logic unused_last;
   assign unused_last = ^last;
   assign elig        = req;
`endif

   // Walk offsets from the far end so the nearest eligible index after ptr wins.
   always_comb begin
      int idx;
      idx     = 0;
      sel_vld = 1'b0;
      sel_idx = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = int'(ptr_reg) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (elig[idx]) begin
            sel_vld = 1'b1;
            sel_idx = IW'(idx);
         end
      end
   end

   assign g_inc = (g_reg == IW'(N_REQ - 1)) ? '0 : g_reg + IW'(1);

   always_comb begin
      state_next    = state_reg;
      ptr_next      = ptr_reg;
      g_next        = g_reg;
      grant_next    = grant_reg;
      ack_next      = ack_reg;
      rsp_req_next  = rsp_req_reg;
      rsp_data_next = rsp_data_reg;
`ifdef FT232R_ARB_PKT_LOCK_EN
      lock_vld_next = lock_vld_reg;
      lock_idx_next = lock_idx_reg;
      last_next     = last_reg;
`endif
      case (state_reg)
         ST_IDLE: begin
            if (sel_vld) begin
               state_next    = ST_SEND;
               g_next        = sel_idx;
               grant_next    = ONE << sel_idx;
               rsp_data_next = byte_arr[sel_idx];
               rsp_req_next  = 1'b1;
`ifdef FT232R_ARB_PKT_LOCK_EN
               last_next     = last[sel_idx];
`endif
            end
         end
         ST_SEND: begin
            if (rsp_ack) begin
               state_next   = ST_ACK;
               rsp_req_next = 1'b0;
               ack_next     = grant_reg;
            end
         end
         ST_ACK: begin
            if (!req[g_reg]) begin
               state_next = ST_IDLE;
               ack_next   = '0;
               grant_next = '0;
`ifdef FT232R_ARB_PKT_LOCK_EN
               if (last_reg) begin
                  lock_vld_next = 1'b0;
                  ptr_next      = g_inc;
               end else begin
                  lock_vld_next = 1'b1;
                  lock_idx_next = g_reg;
               end
`else
               ptr_next   = g_inc;
`endif
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         ptr_reg      <= '0;
         g_reg        <= '0;
         grant_reg    <= '0;
         ack_reg      <= '0;
         rsp_req_reg  <= 1'b0;
         rsp_data_reg <= 8'h00;
`ifdef FT232R_ARB_PKT_LOCK_EN
         lock_vld_reg <= 1'b0;
         lock_idx_reg <= '0;
         last_reg     <= 1'b0;
`endif
      end else begin
         state_reg    <= state_next;
         ptr_reg      <= ptr_next;
         g_reg        <= g_next;
         grant_reg    <= grant_next;
         ack_reg      <= ack_next;
         rsp_req_reg  <= rsp_req_next;
         rsp_data_reg <= rsp_data_next;
`ifdef FT232R_ARB_PKT_LOCK_EN
         lock_vld_reg <= lock_vld_next;
         lock_idx_reg <= lock_idx_next;
         last_reg     <= last_next;
`endif
      end
   end

   assign ack      = ack_reg;
   assign grant    = grant_reg;
   assign rsp_req  = rsp_req_reg;
   assign rsp_data = rsp_data_reg;
   assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ft232r_rsp_arb.sv
// Randomized bench for ft232r_rsp_arb: requester/adapter agents, a transaction-level owner model,
// per-cycle output comparison and a few literal grant-order expectations.
module tb_ft232r_rsp_arb;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req, last, ack, grant;
   logic [8*N-1:0] data;
   logic           rsp_req, rsp_ack, busy;
   logic [7:0]     rsp_data;

   always #5 clk = ~clk;

   ft232r_rsp_arb #(.N_REQ(N)) dut (
      .clk(clk), .rst(rst), .req(req), .data(data), .last(last), .ack(ack),
      .rsp_req(rsp_req), .rsp_data(rsp_data), .rsp_ack(rsp_ack),
      .grant(grant), .busy(busy)
   );

   int n_cmp = 0;
   int n_fail = 0;

   // Stimulus configuration
   logic [8:0] txq [N][$];
   int  st [N];
   int  dly [N];
   int  raise_max, ad_min, ad_max, mut_pct, viol_pct, stray_cnt;
   bit  mut_always;

   task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      check(name, act === exp, act, exp);
   endtask

   // Reference model: who owns the path and whether its byte has gone out.
   int         m_owner = -1;
   int         m_ptr = 0;
   int         m_lock = -1;
   int         m_wait [N];
   int         m_worst = 0;
   bit         m_sent = 1'b0;
   bit         m_valid = 1'b0;
   logic [7:0] m_data = 8'h00;
   int         gnt_log [$];
`ifdef FT232R_ARB_PKT_LOCK_EN
   bit         m_last = 1'b0;
`endif

   always @(posedge clk) begin
      int win;
      win = -1;
      if (rst) begin
         m_owner = -1; m_ptr = 0; m_lock = -1; m_data = 8'h00; m_sent = 1'b0; m_valid = 1'b1;
         for (int j = 0; j < N; j++) m_wait[j] = 0;
      end else if (m_owner < 0) begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (win < 0 && req[j] && (m_lock < 0 || m_lock == j)) win = j;
         end
         if (win >= 0) begin
            m_owner = win;
            m_sent  = 1'b0;
            m_data  = data[8*win +: 8];
`ifdef FT232R_ARB_PKT_LOCK_EN
            m_last  = last[win];
`endif
            gnt_log.push_back(win);
            for (int j = 0; j < N; j++) begin
               if (j != win && req[j]) begin
                  m_wait[j]++;
                  if (m_wait[j] > m_worst) m_worst = m_wait[j];
               end
            end
            m_wait[win] = 0;
         end
      end else if (!m_sent) begin
         if (rsp_ack) m_sent = 1'b1;
      end else if (!req[m_owner]) begin
`ifdef FT232R_ARB_PKT_LOCK_EN
         if (m_last) begin
            m_lock = -1;
            m_ptr  = (m_owner + 1) % N;
         end else begin
            m_lock = m_owner;
         end
`else
         m_ptr = (m_owner + 1) % N;
`endif
         m_owner = -1;
      end
   end

   task automatic compare_loop();
      logic [N-1:0] eg, ea;
      bit prev_rr, seen_byte;
      int low_cnt;
      prev_rr = 1'b0; seen_byte = 1'b0; low_cnt = 0;
      forever begin
         @(negedge clk);
         if (m_valid) begin
            eg = '0; ea = '0;
            if (m_owner >= 0) begin
               eg[m_owner] = 1'b1;
               if (m_sent) ea[m_owner] = 1'b1;
            end
            check_eq("grant", grant, eg);
            check_eq("ack", ack, ea);
            check_eq("rsp_req", rsp_req, (m_owner >= 0) && !m_sent);
            check_eq("rsp_data", rsp_data, m_data);
            check_eq("busy", busy, m_owner >= 0);
            check("ack_onehot0", $onehot0(ack), ack, 0);
            if (rsp_req && !prev_rr) begin
               if (seen_byte) check("rsp_req_gap", low_cnt >= 2, low_cnt, 2);
               seen_byte = 1'b1;
               low_cnt = 0;
            end else if (!rsp_req) begin
               low_cnt++;
            end
            prev_rr = rsp_req;
         end
      end
   endtask

   // Requester agents and the adapter, all acting on the falling edge.
   task automatic drive_loop();
      bit mutated [N];
      bit prev_rr, pend;
      int acnt;
      logic [8:0] e;
      prev_rr = 1'b0; pend = 1'b0; acnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            req = '0; last = '0; rsp_ack = 1'b0; pend = 1'b0; prev_rr = 1'b0;
            for (int i = 0; i < N; i++) begin
               st[i] = 0; dly[i] = 0; txq[i].delete();
            end
         end else begin
            for (int i = 0; i < N; i++) begin
               case (st[i])
                  0: if (dly[i] > 0) dly[i]--;
                     else if (txq[i].size() > 0) begin
                        e = txq[i].pop_front();
                        data[8*i +: 8] = e[7:0];
                        last[i] = e[8];
                        req[i] = 1'b1;
                        mutated[i] = 1'b0;
                        st[i] = 1;
                     end
                  1: if (ack[i]) begin
                        if ($urandom_range(0, 2) != 0) begin req[i] = 1'b0; st[i] = 2; end
                     end else if (grant[i]) begin
                        if (!mutated[i] && (mut_always || $urandom_range(0, 99) < mut_pct)) begin
                           data[8*i +: 8] = data[8*i +: 8] ^ 8'h33;
                           mutated[i] = 1'b1;
                        end else if ($urandom_range(0, 99) < viol_pct) begin
                           req[i] = 1'b0; st[i] = 3;
                        end
                     end
                  2: if (!ack[i]) begin st[i] = 0; dly[i] = $urandom_range(0, raise_max); end
                  default: if (!grant[i]) begin st[i] = 0; dly[i] = $urandom_range(0, raise_max); end
               endcase
            end
            rsp_ack = 1'b0;
            if (stray_cnt > 0) begin
               stray_cnt--;
               if (stray_cnt == 0) rsp_ack = 1'b1;
            end
            if (rsp_req && !prev_rr) begin
               pend = 1'b1;
               acnt = $urandom_range(ad_min, ad_max);
            end else if (pend) begin
               acnt--;
               if (acnt <= 0) begin rsp_ack = 1'b1; pend = 1'b0; end
            end
            prev_rr = rsp_req;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_quiet(input string name, input int budget);
      int t;
      bit q;
      t = 0;
      do begin
         @(negedge clk);
         q = !busy;
         for (int i = 0; i < N; i++) if (txq[i].size() != 0 || st[i] != 0) q = 1'b0;
         t++;
      end while (!q && t < budget);
      if (!q) check(name, 1'b0, t, budget);
   endtask

   task automatic wait_grant(input string name, input int budget);
      int t;
      t = 0;
      while (grant == '0 && t < budget) begin @(negedge clk); t++; end
      if (grant == '0) check(name, 1'b0, t, budget);
   endtask

   task automatic check_log(input string name, input int base, input int exp [$]);
      check_eq({name, "_count"}, gnt_log.size() - base, exp.size());
      for (int k = 0; k < exp.size(); k++) begin
         if (base + k < gnt_log.size()) check_eq(name, gnt_log[base + k], exp[k]);
         else check(name, 1'b0, 32'hFFFF_FFFF, exp[k]);
      end
   endtask

   initial begin
      int base, t;
      int e [$];
      rst = 1'b1; req = '0; data = '0; last = '0; rsp_ack = 1'b0;
      raise_max = 0; ad_min = 3; ad_max = 3; mut_pct = 0; viol_pct = 0;
      mut_always = 1'b0; stray_cnt = 0;
      fork
         compare_loop();
         drive_loop();
      join_none
      repeat (3) @(negedge clk);
      check_eq("reset_grant", grant, 0);
      check_eq("reset_ack", ack, 0);
      check_eq("reset_rsp_req", rsp_req, 0);
      check_eq("reset_rsp_data", rsp_data, 8'h00);
      check_eq("reset_busy", busy, 0);
      rst = 1'b0;

      // Single requester, adapter answers 10 cycles later
      ad_min = 10; ad_max = 10;
      base = gnt_log.size();
      txq[2].push_back({1'b1, 8'hA5});
      wait_grant("t1_grant_timeout", 50);
      check_eq("t1_grant", grant, 4'b0100);
      check_eq("t1_rsp_data", rsp_data, 8'hA5);
      check_eq("t1_rsp_req", rsp_req, 1'b1);
      t = 0;
      while (!ack[2] && t < 50) begin @(negedge clk); t++; end
      check_eq("t1_ack", ack, 4'b0100);
      wait_quiet("t1_quiet", 200);
      check_eq("t1_busy_end", busy, 0);
      e = '{2};
      check_log("t1_order", base, e);

      // All four requesters, two bytes each
      do_reset();
      ad_min = 3; ad_max = 5;
      base = gnt_log.size();
      for (int i = 0; i < N; i++) begin
         txq[i].push_back({1'b1, 8'(8'h10 + i)});
         txq[i].push_back({1'b1, 8'(8'h20 + i)});
      end
      wait_quiet("t2_quiet", 500);
      e = '{0, 1, 2, 3, 0, 1, 2, 3};
      check_log("t2_order", base, e);

      // Reset during SEND, stray rsp_ack after release
      do_reset();
      ad_min = 40; ad_max = 40;
      txq[1].push_back({1'b1, 8'h5A});
      wait_grant("t3_grant_timeout", 50);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      stray_cnt = 5;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         check_eq("t3_ack", ack, 0);
         check_eq("t3_grant", grant, 0);
         check_eq("t3_rsp_req", rsp_req, 0);
         check_eq("t3_busy", busy, 0);
      end

      // Data bus changes during SEND must not reach rsp_data
      ad_min = 6; ad_max = 6; mut_always = 1'b1;
      txq[1].push_back({1'b1, 8'h11});
      t = 0;
      while (!ack[1] && t < 60) begin @(negedge clk); t++; end
      check_eq("t4_ack", ack, 4'b0010);
      check_eq("t4_rsp_data", rsp_data, 8'h11);
      wait_quiet("t4_quiet", 200);
      mut_always = 1'b0;

      // Packet lock: requester 0 sends a 3-byte packet while requester 1 waits
      do_reset();
      ad_min = 3; ad_max = 3;
      base = gnt_log.size();
      txq[0].push_back({1'b0, 8'hAA});
      txq[0].push_back({1'b0, 8'hBB});
      txq[0].push_back({1'b1, 8'hCC});
      txq[1].push_back({1'b1, 8'hD1});
      txq[1].push_back({1'b1, 8'hD2});
      wait_quiet("t5_quiet", 500);
`ifdef FT232R_ARB_PKT_LOCK_EN
      e = '{0, 0, 0, 1, 1};
`else
      e = '{0, 1, 0, 1, 0};
`endif
      check_log("t5_order", base, e);

      // Randomized traffic
      do_reset();
      raise_max = 6; ad_min = 1; ad_max = 12; mut_pct = 20; viol_pct = 2;
      base = gnt_log.size();
      for (int i = 0; i < N; i++) begin
         for (int k = 0; k < 40; k++) begin
            bit lb;
            lb = (k == 39) || ($urandom_range(0, 3) == 0);
            txq[i].push_back({lb, 8'($urandom_range(0, 255))});
         end
      end
      wait_quiet("t6_quiet", 30000);
      check_eq("t6_grant_count", gnt_log.size() - base, 4 * 40);
`ifndef FT232R_ARB_PKT_LOCK_EN
      check("fairness", m_worst <= N - 1, m_worst, N - 1);
`endif
      repeat (5) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete, compared=%0d mismatched=%0d", n_cmp, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
